// File: rtl/alu_serial_seq.sv
// Bit-serial operand sequencer for a 1-bit ALU slice: streams operands LSB first,
// closes the carry loop through a flop and collects the slice output into a word.
module alu_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic [2:0]       alu_m,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_c,
  input  logic             alu_out_in,
  input  logic             alu_next_in,
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled only in IDLE; an accepted request yields exactly
  // one done pulse WIDTH+1 cycles later, an illegal mode yields one err pulse instead.

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_sa;
  logic [WIDTH-1:0]   r_sb;
  // The lowest accumulated bit is shifted out before the word completes, so it is never stored.
  logic [WIDTH-1:1]   r_acc;
  logic [2:0]         r_m;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [WIDTH-1:0]   r_result;
  logic               r_cout;

  logic               w_legal;
  logic               w_last;
  logic               w_run;
  logic               w_is_add;
  logic [WIDTH-1:0]   w_acc_next;
  logic               w_carry_next;

  assign w_legal      = (mode <= 3'b100);
  assign w_last       = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_run        = (r_state == S_RUN);
  assign w_is_add     = (r_m == 3'b000);
  assign w_acc_next   = {alu_out_in, r_acc[WIDTH-1:1]};
  assign w_carry_next = w_is_add ? alu_next_in : 1'b0;

  // Slice drive is gated so the slice sees a quiet NOP outside RUN.
  assign alu_m = w_run ? r_m     : 3'b000;
  assign alu_a = w_run ? r_sa[0] : 1'b0;
  assign alu_b = w_run ? r_sb[0] : 1'b0;
  assign alu_c = w_run ? r_carry : 1'b0;

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign result    = r_result;
  assign cout      = r_cout;
  assign dbg_state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_acc    <= '0;
      r_m      <= 3'b000;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_legal) begin
              r_sa    <= opa;
              r_sb    <= opb;
              r_m     <= mode;
              r_carry <= (mode == 3'b000) ? cin : 1'b0;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_next[WIDTH-1:1];
          r_sa    <= r_sa >> 1;
          r_sb    <= r_sb >> 1;
          r_carry <= w_carry_next;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_result <= w_acc_next;
            r_cout   <= w_carry_next;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Bench for alu_serial_seq with a behavioural 1-bit slice, arithmetic reference
// model and a done-driven scoreboard.
module tb_alu_serial_seq;

  localparam int WIDTH = 8;
  localparam int W     = WIDTH + 1;

  logic             clk;
  logic             rst;
  logic             start;
  logic [2:0]       mode;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             cin;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic [2:0]       alu_m;
  logic             alu_a;
  logic             alu_b;
  logic             alu_c;
  logic             alu_out_in;
  logic             alu_next_in;
  logic [1:0]       dbg_state;

  alu_serial_seq #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .opa         (opa),
    .opb         (opb),
    .cin         (cin),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .result      (result),
    .cout        (cout),
    .alu_m       (alu_m),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_c       (alu_c),
    .alu_out_in  (alu_out_in),
    .alu_next_in (alu_next_in),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- 1-bit slice ----------------
  always_comb begin
    alu_out_in  = 1'b0;
    alu_next_in = 1'b0;
    case (alu_m)
      3'b000: begin
        alu_out_in  = alu_a ^ alu_b ^ alu_c;
        alu_next_in = (alu_a & alu_b) | (alu_c & (alu_a ^ alu_b));
      end
      3'b001: begin alu_out_in = alu_a & alu_b;    alu_next_in = alu_a | alu_b; end
      3'b010: begin alu_out_in = alu_a | alu_b;    alu_next_in = alu_a | alu_b; end
      3'b011: begin alu_out_in = alu_a ^ alu_b;    alu_next_in = alu_a | alu_b; end
      3'b100: begin alu_out_in = ~(alu_a ^ alu_b); alu_next_in = alu_a | alu_b; end
      default: begin alu_out_in = 1'b0; alu_next_in = 1'b0; end
    endcase
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_issued = 0;
  logic [W-1:0]     exp_q[$];
  logic [WIDTH-1:0] last_result;
  logic             last_cout;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: {cout, result} from plain arithmetic on whole words.
  function automatic logic [W-1:0] ref_op(logic [2:0] m, logic [WIDTH-1:0] a,
                                          logic [WIDTH-1:0] b, logic c);
    case (m)
      3'b000:  return {1'b0, a} + {1'b0, b} + W'(c);
      3'b001:  return {1'b0, a & b};
      3'b010:  return {1'b0, a | b};
      3'b011:  return {1'b0, a ^ b};
      default: return {1'b0, ~(a ^ b)};
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (!rst && done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got result 0x%0h with empty expected queue at %0t",
                 result, $time);
      end else begin
        e = exp_q.pop_front();
        chk("result", 32'(result), 32'(e[WIDTH-1:0]));
        chk("cout", 32'(cout), 32'(e[WIDTH]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [2:0] m, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic c, input bit hammer);
    logic [W-1:0]     exp;
    logic [WIDTH-1:0] cvec;
    exp  = ref_op(m, a, b, c);
    // Carry into bit i recovered from the full sum: s[i] = a[i]^b[i]^c_i.
    cvec = (m == 3'b000) ? (exp[WIDTH-1:0] ^ a ^ b) : '0;
    @(negedge clk);
    start = 1'b1; mode = m; opa = a; opb = b; cin = c;
    @(posedge clk);
    exp_q.push_back(exp);
    n_issued++;
    #1;
    start = hammer;
    opa = WIDTH'($urandom); opb = WIDTH'($urandom); cin = 1'($urandom);
    mode = 3'($urandom_range(0, 7));
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_run", 32'(done), 32'd0);
      chk("err_run", 32'(err), 32'd0);
      chk("alu_m", 32'(alu_m), 32'(m));
      chk("alu_a", 32'(alu_a), 32'(a[i]));
      chk("alu_b", 32'(alu_b), 32'(b[i]));
      chk("alu_c", 32'(alu_c), 32'(cvec[i]));
      chk("result_hold", 32'(result), 32'(last_result));
      if (hammer) begin
        opa = WIDTH'($urandom); opb = WIDTH'($urandom); cin = 1'($urandom);
        mode = 3'($urandom_range(0, 7));
      end
    end
    @(negedge clk);
    chk("done_latency", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("alu_m_done", 32'(alu_m), 32'd0);
    chk("alu_c_done", 32'(alu_c), 32'd0);
    start = 1'b0;
    last_result = exp[WIDTH-1:0];
    last_cout   = exp[WIDTH];
    @(posedge clk);
  endtask

  task automatic illegal_op();
    @(negedge clk);
    start = 1'b1;
    mode  = 3'($urandom_range(5, 7));
    opa   = WIDTH'($urandom); opb = WIDTH'($urandom); cin = 1'($urandom);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("err_pulse", 32'(err), 32'd1);
    chk("busy_illegal", 32'(busy), 32'd0);
    chk("done_illegal", 32'(done), 32'd0);
    chk("result_illegal", 32'(result), 32'(last_result));
    chk("cout_illegal", 32'(cout), 32'(last_cout));
    @(posedge clk);
    #1;
    chk("err_one_cycle", 32'(err), 32'd0);
    chk("busy_after_illegal", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_cout"}, 32'(cout), 32'd0);
    chk({tag, "_alu_m"}, 32'(alu_m), 32'd0);
    chk({tag, "_alu_abc"}, 32'({alu_a, alu_b, alu_c}), 32'd0);
  endtask

  task automatic reset_mid_op();
    @(negedge clk);
    start = 1'b1; mode = 3'b000; opa = 8'h5A; opb = 8'h3C; cin = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_result = '0;
    last_cout   = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("post_reset");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; mode = 3'b000; opa = '0; opb = '0; cin = 1'b0;
    last_result = '0;
    last_cout   = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run_op(3'b000, 8'h5A, 8'h3C, 1'b0, 1'b0);
    run_op(3'b000, 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(3'b000, 8'h7F, 8'h00, 1'b1, 1'b0);
    for (int m = 1; m <= 4; m++) run_op(3'(m), 8'hAA, 8'h0F, 1'b1, 1'b0);

    illegal_op();
    run_op(3'b001, 8'hC3, 8'h5E, 1'b1, 1'b1);

    reset_mid_op();
    run_op(3'b000, 8'h01, 8'h02, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) illegal_op();
      run_op(3'($urandom_range(0, 4)), WIDTH'($urandom), WIDTH'($urandom),
             1'($urandom), bit'($urandom_range(0, 3) == 0));
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("done_count", 32'(n_done), 32'(n_issued));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
